// File: rtl/trng_sampler.sv
// Back end for the self-timed-ring entropy source. It controls the ring reset, synchronizes
// the stage outputs, runs a repetition-count test, debiases the raw bits and packs them into words.
module trng_sampler #(
    parameter int LEN       = 8,
    parameter int WORD_W    = 32,
    parameter int DIV       = 4,
    parameter int WARMUP    = 64,
    parameter int RCT_LIMIT = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              en,
    input  logic [LEN-1:0]    sin,
    output logic              str_rstn,
    output logic [WORD_W-1:0] rnd_data,
    output logic              rnd_valid,
    input  logic              rnd_ready,
    output logic              fail,
    input  logic              fail_clr
);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int WU_W  = (WARMUP > 1) ? $clog2(WARMUP) : 1;
    localparam int RCT_W = $clog2(RCT_LIMIT + 1);
    localparam int CNT_W = $clog2(WORD_W + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WARMUP = 2'd1,
        ST_RUN    = 2'd2,
        ST_FAIL   = 2'd3
    } state_t;

    state_t              state_reg, state_next;
    logic                str_rstn_reg, str_rstn_next;
    logic                fail_reg, fail_next;
    logic [WU_W-1:0]     wu_reg;
    logic [DIV_W-1:0]    div_reg;
    logic [RCT_W-1:0]    rct_cnt_reg;
    logic                prev_reg;
    logic                phase_reg;
    logic                a_reg;
    logic [WORD_W-1:0]   sr_reg;
    logic [CNT_W-1:0]    cnt_reg;
    logic [WORD_W-1:0]   data_reg;
    logic                valid_reg;

    logic [LEN-1:0]      sync_q;
    logic                raw;
    logic                wu_done;
    logic                tick;
    logic                keep;
    logic                rct_same;
    logic                rct_trip;
    logic                bit_valid;
    logic                full;
    logic                reload;
    logic                xfer;

    // Two-flop synchronizer per ring stage; only the XOR of the stable stage is used.
    generate
        for (genvar gi = 0; gi < LEN; gi++) begin : g_sync
            logic meta_reg;
            logic stab_reg;
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    meta_reg <= 1'b0;
                    stab_reg <= 1'b0;
                end else begin
                    meta_reg <= sin[gi];
                    stab_reg <= meta_reg;
                end
            end
            assign sync_q[gi] = stab_reg;
        end
    endgenerate

    assign raw     = ^sync_q;
    assign wu_done = (wu_reg == WU_W'(WARMUP - 1));
    assign tick    = (state_reg == ST_RUN) && (div_reg == DIV_W'(DIV - 1));

    // The run counter holds 0 only before the first tick of a RUN entry.
    assign rct_same  = (rct_cnt_reg != '0) && (raw == prev_reg);
    assign rct_trip  = tick && rct_same && (rct_cnt_reg == RCT_W'(RCT_LIMIT - 1));
    assign bit_valid = tick && phase_reg && (a_reg != raw);

    // Datapath state survives only while RUN continues; any exit discards partial work.
    assign keep   = (state_reg == ST_RUN) && (state_next == ST_RUN);
    assign full   = (cnt_reg == CNT_W'(WORD_W));
    assign xfer   = valid_reg && rnd_ready;
    assign reload = keep && full && (!valid_reg || rnd_ready);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg    <= ST_IDLE;
            str_rstn_reg <= 1'b0;
            fail_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            str_rstn_reg <= str_rstn_next;
            fail_reg     <= fail_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            ST_IDLE:   if (en) state_next = ST_WARMUP;
            ST_WARMUP: begin
                if (!en)          state_next = ST_IDLE;
                else if (wu_done) state_next = ST_RUN;
            end
            ST_RUN: begin
                if (rct_trip) state_next = ST_FAIL;
                else if (!en) state_next = ST_IDLE;
            end
            ST_FAIL:   if (fail_clr) state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // Ring release and fail flag are registered images of the state being entered.
    always_comb begin
        str_rstn_next = 1'b0;
        fail_next     = 1'b0;
        unique case (state_next)
            ST_WARMUP: str_rstn_next = 1'b1;
            ST_RUN:    str_rstn_next = 1'b1;
            ST_FAIL:   fail_next     = 1'b1;
            default:   str_rstn_next = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wu_reg  <= '0;
            div_reg <= '0;
        end else begin
            if ((state_reg == ST_WARMUP) && (state_next == ST_WARMUP))
                wu_reg <= wu_reg + 1'b1;
            else
                wu_reg <= '0;
            if (keep && !tick)
                div_reg <= div_reg + 1'b1;
            else
                div_reg <= '0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rct_cnt_reg <= '0;
            prev_reg    <= 1'b0;
            phase_reg   <= 1'b0;
            a_reg       <= 1'b0;
            sr_reg      <= '0;
            cnt_reg     <= '0;
        end else if (!keep) begin
            rct_cnt_reg <= '0;
            prev_reg    <= 1'b0;
            phase_reg   <= 1'b0;
            a_reg       <= 1'b0;
            sr_reg      <= '0;
            cnt_reg     <= '0;
        end else begin
            if (tick) begin
                rct_cnt_reg <= rct_same ? rct_cnt_reg + 1'b1 : RCT_W'(1);
                prev_reg    <= raw;
                phase_reg   <= ~phase_reg;
                if (!phase_reg)
                    a_reg <= raw;
            end
            // A bit arriving on a reload edge becomes the first bit of the next word.
            if (reload) begin
                cnt_reg <= bit_valid ? CNT_W'(1) : '0;
                if (bit_valid)
                    sr_reg <= {sr_reg[WORD_W-2:0], a_reg};
            end else if (bit_valid && !full) begin
                sr_reg  <= {sr_reg[WORD_W-2:0], a_reg};
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    // Entering or holding FAIL drops any pending word, even one being reloaded.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            data_reg  <= '0;
            valid_reg <= 1'b0;
        end else if (state_next == ST_FAIL) begin
            valid_reg <= 1'b0;
        end else if (reload) begin
            data_reg  <= sr_reg;
            valid_reg <= 1'b1;
        end else if (xfer) begin
            valid_reg <= 1'b0;
        end
    end

    assign str_rstn  = str_rstn_reg;
    assign fail      = fail_reg;
    assign rnd_data  = data_reg;
    assign rnd_valid = valid_reg;

endmodule
